rdma_pkt_filter: RTL and testbench

Sits between the Ethernet MAC RX stream and the RDMA receive engine. Examines the first 64-byte beat of every incoming frame as an RDMA header and decides whether the whole frame is forwarded or discarded. Only well-formed RDMA frames are forwarded, so the downstream engine always sees a header beat followed by at least one data beat. Counts forwarded and dropped packets.

---
 rtl/rdma_pkg.sv | 40 ++++
 rtl/axis_skid_buf.sv | 55 +++++
 rtl/rdma_pkt_filter.sv | 162 ++++++++++++++++
 tb/tb_rdma_pkt_filter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdma_pkg : RDMA header offsets, protocol constants and field helpers
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
package rdma_pkg;

   // Byte offsets of header fields within the first 64-byte beat
   localparam int OFF_DST_MAC    = 0;
   localparam int OFF_ETH_TYPE   = 12;
   localparam int OFF_IP_VER_IHL = 14;
   localparam int OFF_IP_PROTO   = 23;
   localparam int OFF_UDP_DST    = 36;
   localparam int OFF_UDP_LEN    = 38;
   localparam int OFF_RDMA_MAGIC = 42;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL    = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
   localparam int          UDP_HDR_LEN   = 8;
   localparam int          RDMA_HDR_LEN  = 22;
   localparam logic [15:0] RDMA_MAGIC    = 16'h0122;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PASS = 2'd1,
      S_DROP = 2'd2
   } filt_state_t;

   function automatic logic [7:0] hdr_byte(input logic [511:0] d, input int off);
      return d[off*8 +: 8];
   endfunction

   // Wire order is big-endian for multi-byte fields
   function automatic logic [15:0] hdr_u16(input logic [511:0] d, input int off);
      return {hdr_byte(d, off), hdr_byte(d, off + 1)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_skid_buf : 2-entry registered skid buffer, full throughput, 1-cycle latency
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
module axis_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_valid;
   logic             w_in_fire;

   assign in_ready  = ~r_skid_valid;
   assign w_in_fire = in_valid & ~r_skid_valid;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || out_ready) begin
         // Output slot frees up: the skid entry is older, so it goes first
         if (r_skid_valid) begin
            r_out_data   <= r_skid_data;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= w_in_fire;
            if (w_in_fire) begin
               r_out_data <= in_data;
            end
         end
      end else if (w_in_fire) begin
         r_skid_data  <= in_data;
         r_skid_valid <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rdma_pkt_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdma_pkt_filter : forwards well-formed RDMA frames, drops the rest, counts both
// Optional dst-MAC check: RDMA_FILTER_MAC_CHECK_EN.  Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module rdma_pkt_filter
   import rdma_pkg::*;
#(
   parameter int          DATA_WBITS     = 512,
   parameter int          DATA_WBYTS     = DATA_WBITS / 8,
   parameter logic [15:0] RDMA_MAGIC     = rdma_pkg::RDMA_MAGIC,
   parameter int          MAX_DATA_BYTES = 16384
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [15:0]           udp_port,
   input  logic [47:0]           local_mac,
   input  logic [DATA_WBITS-1:0] AXIS_IN_TDATA,
   input  logic [DATA_WBYTS-1:0] AXIS_IN_TKEEP,
   input  logic                  AXIS_IN_TVALID,
   input  logic                  AXIS_IN_TLAST,
   output logic                  AXIS_IN_TREADY,
   output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
   output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
   output logic                  AXIS_OUT_TVALID,
   output logic                  AXIS_OUT_TLAST,
   input  logic                  AXIS_OUT_TREADY,
   output logic [31:0]           pkts_passed,
   output logic [31:0]           pkts_dropped
);

   localparam int          c_buf_w   = DATA_WBITS + DATA_WBYTS + 1;
   // Smallest UDP length carries at least one payload byte after the RDMA header
   localparam logic [15:0] c_len_min = 16'(UDP_HDR_LEN + RDMA_HDR_LEN + 1);
   localparam logic [15:0] c_len_max = 16'(UDP_HDR_LEN + RDMA_HDR_LEN + MAX_DATA_BYTES);

   filt_state_t  r_state;
   filt_state_t  w_next_state;
   logic [31:0]  r_pkts_passed;
   logic [31:0]  r_pkts_dropped;
   logic         w_in_tready;
   logic         w_buf_valid;
   logic         w_buf_ready;
   logic         w_pass_done;
   logic         w_drop_done;
   logic         w_hdr_ok;
   logic         w_mac_ok;
   logic [47:0]  w_dst_mac;
   logic [15:0]  w_udp_len;
   logic [c_buf_w-1:0] w_buf_in;
   logic [c_buf_w-1:0] w_buf_out;

   assign w_dst_mac = {hdr_u16(AXIS_IN_TDATA, OFF_DST_MAC),
                       hdr_u16(AXIS_IN_TDATA, OFF_DST_MAC + 2),
                       hdr_u16(AXIS_IN_TDATA, OFF_DST_MAC + 4)};
   assign w_udp_len = hdr_u16(AXIS_IN_TDATA, OFF_UDP_LEN);

`ifdef RDMA_FILTER_MAC_CHECK_EN
   assign w_mac_ok = (w_dst_mac == local_mac) || (w_dst_mac == 48'hFFFF_FFFF_FFFF);
`else
   logic w_unused_mac;
   assign w_mac_ok     = 1'b1;
   assign w_unused_mac = ^{local_mac, w_dst_mac};
`endif

   assign w_hdr_ok = (hdr_u16(AXIS_IN_TDATA, OFF_ETH_TYPE) == ETH_TYPE_IPV4)
                  && (hdr_byte(AXIS_IN_TDATA, OFF_IP_VER_IHL) == IP_VER_IHL)
                  && (hdr_byte(AXIS_IN_TDATA, OFF_IP_PROTO) == IP_PROTO_UDP)
                  && (hdr_u16(AXIS_IN_TDATA, OFF_UDP_DST) == udp_port)
                  && (hdr_u16(AXIS_IN_TDATA, OFF_RDMA_MAGIC) == RDMA_MAGIC)
                  && (w_udp_len >= c_len_min)
                  && (w_udp_len <= c_len_max)
                  && !AXIS_IN_TLAST
                  && w_mac_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_HDR;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_tready  = w_buf_ready;
      w_buf_valid  = 1'b0;
      w_pass_done  = 1'b0;
      w_drop_done  = 1'b0;
      case (r_state)
         S_HDR: begin
            // Rejected headers are swallowed regardless of buffer occupancy
            w_in_tready = w_hdr_ok ? w_buf_ready : 1'b1;
            w_buf_valid = AXIS_IN_TVALID & w_hdr_ok;
            if (AXIS_IN_TVALID && w_in_tready) begin
               if (w_hdr_ok) begin
                  w_next_state = S_PASS;
               end else if (!AXIS_IN_TLAST) begin
                  w_next_state = S_DROP;
               end else begin
                  w_drop_done = 1'b1;
               end
            end
         end
         S_PASS: begin
            w_buf_valid = AXIS_IN_TVALID;
            if (AXIS_IN_TVALID && w_buf_ready && AXIS_IN_TLAST) begin
               w_next_state = S_HDR;
               w_pass_done  = 1'b1;
            end
         end
         S_DROP: begin
            w_in_tready = 1'b1;
            if (AXIS_IN_TVALID && AXIS_IN_TLAST) begin
               w_next_state = S_HDR;
               w_drop_done  = 1'b1;
            end
         end
         default: begin
            w_next_state = S_HDR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pkts_passed  <= '0;
         r_pkts_dropped <= '0;
      end else begin
         if (w_pass_done && (r_pkts_passed != 32'hFFFF_FFFF)) begin
            r_pkts_passed <= r_pkts_passed + 32'd1;
         end
         if (w_drop_done && (r_pkts_dropped != 32'hFFFF_FFFF)) begin
            r_pkts_dropped <= r_pkts_dropped + 32'd1;
         end
      end
   end

   assign w_buf_in = {AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST};

   axis_skid_buf #(
      .WIDTH (c_buf_w)
   ) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .in_data   (w_buf_in),
      .in_valid  (w_buf_valid),
      .in_ready  (w_buf_ready),
      .out_data  (w_buf_out),
      .out_valid (AXIS_OUT_TVALID),
      .out_ready (AXIS_OUT_TREADY)
   );

   assign AXIS_IN_TREADY = w_in_tready;
   assign AXIS_OUT_TDATA = w_buf_out[c_buf_w-1 -: DATA_WBITS];
   assign AXIS_OUT_TKEEP = w_buf_out[DATA_WBYTS:1];
   assign AXIS_OUT_TLAST = w_buf_out[0];
   assign pkts_passed    = r_pkts_passed;
   assign pkts_dropped   = r_pkts_dropped;

endmodule
`default_nettype wire

// File: tb/tb_rdma_pkt_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rdma_pkt_filter : directed self-checking bench for rdma_pkt_filter
// Rev 1.0            : initial release
// ---------------------------------------------------------------------------
module tb_rdma_pkt_filter;

   localparam logic [47:0] MAC_LOCAL = 48'h0200_0000_0001;

   logic         clk = 1'b0;
   logic         resetn;
   logic [15:0]  udp_port;
   logic [47:0]  local_mac;
   logic [511:0] in_tdata;
   logic [63:0]  in_tkeep;
   logic         in_tvalid;
   logic         in_tlast;
   logic         in_tready;
   logic [511:0] out_tdata;
   logic [63:0]  out_tkeep;
   logic         out_tvalid;
   logic         out_tlast;
   logic         out_tready = 1'b1;
   logic [31:0]  pkts_passed;
   logic [31:0]  pkts_dropped;

   int total = 0;
   int bad   = 0;
   bit rand_mode = 1'b0;
   logic [576:0] got_q[$];
   logic [576:0] exp_q[$];

   always #5 clk = ~clk;

   rdma_pkt_filter dut (
      .clk             (clk),
      .resetn          (resetn),
      .udp_port        (udp_port),
      .local_mac       (local_mac),
      .AXIS_IN_TDATA   (in_tdata),
      .AXIS_IN_TKEEP   (in_tkeep),
      .AXIS_IN_TVALID  (in_tvalid),
      .AXIS_IN_TLAST   (in_tlast),
      .AXIS_IN_TREADY  (in_tready),
      .AXIS_OUT_TDATA  (out_tdata),
      .AXIS_OUT_TKEEP  (out_tkeep),
      .AXIS_OUT_TVALID (out_tvalid),
      .AXIS_OUT_TLAST  (out_tlast),
      .AXIS_OUT_TREADY (out_tready),
      .pkts_passed     (pkts_passed),
      .pkts_dropped    (pkts_dropped)
   );

   always @(posedge clk) begin
      #1;
      out_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (resetn === 1'b1 && out_tvalid === 1'b1 && out_tready === 1'b1)
         got_q.push_back({out_tdata, out_tkeep, out_tlast});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [576:0] obs, input logic [576:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_hdr(input logic [47:0] mac, input logic [15:0] port,
                                           input logic [15:0] magic, input logic [15:0] len);
      logic [511:0] d;
      d = '0;
      for (int i = 0; i < 6; i++) d[i*8 +: 8] = mac[(5-i)*8 +: 8];
      d[12*8 +: 8] = 8'h08;
      d[13*8 +: 8] = 8'h00;
      d[14*8 +: 8] = 8'h45;
      d[23*8 +: 8] = 8'd17;
      d[36*8 +: 8] = port[15:8];
      d[37*8 +: 8] = port[7:0];
      d[38*8 +: 8] = len[15:8];
      d[39*8 +: 8] = len[7:0];
      d[42*8 +: 8] = magic[15:8];
      d[43*8 +: 8] = magic[7:0];
      d[50*8 +: 8] = 8'h5A;
      return d;
   endfunction

   task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                            output int stalls);
      logic rdy;
      rdy = 1'b0;
      stalls = 0;
      in_tdata = d;
      in_tkeep = k;
      in_tlast = l;
      in_tvalid = 1'b1;
      for (int n = 0; n < 300 && !rdy; n++) begin
         @(negedge clk);
         rdy = in_tready;
         @(posedge clk);
         #1;
         if (!rdy) stalls++;
      end
      if (!rdy) chk("handshake_timeout", 577'(rdy), 577'd1);
      in_tvalid = 1'b0;
   endtask

   // Header beat, then data beats filled with (id+k); last beat has a partial TKEEP
   task automatic send_frame(input logic [511:0] hdr, input int nb, input logic [7:0] id,
                             input bit pass, output int stalls_total);
      int s;
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
      stalls_total = 0;
      for (int b = 0; b < nb; b++) begin
         l = (b == nb - 1);
         if (b == 0) begin
            d = hdr;
            k = '1;
         end else begin
            d = {64{id + 8'(b)}};
            k = l ? 64'h0000_0000_FFFF_FFFF : '1;
         end
         if (pass) exp_q.push_back({d, k, l});
         send_beat(d, k, l, s);
         stalls_total += s;
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_beats"}, 577'(got_q.size()), 577'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, "_beat"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      logic [511:0] hdr;
      int exp_p, exp_d;

      resetn    = 1'b0;
      udp_port  = 16'd32002;
      local_mac = MAC_LOCAL;
      in_tdata  = '0;
      in_tkeep  = '0;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      idle(3);
      resetn = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_tvalid", 577'(out_tvalid), 577'd0);
      chk("rst_payload", {out_tdata, out_tkeep, out_tlast}, 577'd0);
      chk("rst_passed", 577'(pkts_passed), 577'd0);
      chk("rst_dropped", 577'(pkts_dropped), 577'd0);
      chk("rst_tready", 577'(in_tready), 577'd1);
      @(posedge clk);
      #1;

      // Valid 3-beat frame, with a 1-cycle latency check on the header
      hdr = mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd158);
      exp_q.push_back({hdr, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      send_beat(hdr, '1, 1'b0, s);
      @(negedge clk);
      chk("lat_tvalid", 577'(out_tvalid), 577'd1);
      chk("lat_tdata", 577'(out_tdata), 577'(hdr));
      @(posedge clk);
      #1;
      exp_q.push_back({{64{8'h21}}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      send_beat({64{8'h21}}, '1, 1'b0, s);
      exp_q.push_back({{64{8'h22}}, 64'h0000_0000_FFFF_FFFF, 1'b1});
      send_beat({64{8'h22}}, 64'h0000_0000_FFFF_FFFF, 1'b1, s);
      idle(10);
      check_out("t1");
      chk("t1_passed", 577'(pkts_passed), 577'd1);
      chk("t1_dropped", 577'(pkts_dropped), 577'd0);

      // Wrong UDP port: dropped without ever stalling the input
      send_frame(mk_hdr(MAC_LOCAL, 16'd32003, 16'h0122, 16'd158), 3, 8'h30, 1'b0, s);
      chk("t2_stalls", 577'(s), 577'd0);
      idle(10);
      check_out("t2");
      chk("t2_dropped", 577'(pkts_dropped), 577'd1);

      // Single-beat frame: dropped in S_HDR, counted the very next cycle
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd158), 1, 8'h40, 1'b0, s);
      @(negedge clk);
      chk("t3_dropped", 577'(pkts_dropped), 577'd2);
      chk("t3_tready", 577'(in_tready), 577'd1);
      @(posedge clk);
      #1;

      // Wrong magic
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0123, 16'd158), 3, 8'h50, 1'b0, s);
      idle(10);
      check_out("t3");
      chk("t3b_dropped", 577'(pkts_dropped), 577'd3);
      chk("t3b_passed", 577'(pkts_passed), 577'd1);

      // 10 back-to-back frames with random downstream back-pressure
      rand_mode = 1'b1;
      for (int f = 0; f < 10; f++)
         send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd158), 3, 8'(16 * f + 8'h61),
                    1'b1, s);
      idle(80);
      rand_mode = 1'b0;
      idle(10);
      check_out("t4");
      chk("t4_passed", 577'(pkts_passed), 577'd11);

      // UDP length boundaries 30/31/16414/16415
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd30),    2, 8'h71, 1'b0, s);
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd31),    2, 8'h81, 1'b1, s);
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd16414), 2, 8'h91, 1'b1, s);
      send_frame(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd16415), 2, 8'hA1, 1'b0, s);
      idle(10);
      check_out("len");
      chk("len_passed", 577'(pkts_passed), 577'd13);
      chk("len_dropped", 577'(pkts_dropped), 577'd5);

      // Destination MAC: foreign unicast, then broadcast
`ifdef RDMA_FILTER_MAC_CHECK_EN
      send_frame(mk_hdr(48'h0200_0000_0002, 16'd32002, 16'h0122, 16'd158), 3, 8'hB1, 1'b0, s);
      exp_p = 14;
      exp_d = 6;
`else
      send_frame(mk_hdr(48'h0200_0000_0002, 16'd32002, 16'h0122, 16'd158), 3, 8'hB1, 1'b1, s);
      exp_p = 15;
      exp_d = 5;
`endif
      send_frame(mk_hdr(48'hFFFF_FFFF_FFFF, 16'd32002, 16'h0122, 16'd158), 3, 8'hC1, 1'b1, s);
      idle(10);
      check_out("mac");
      chk("mac_passed", 577'(pkts_passed), 577'(exp_p));
      chk("mac_dropped", 577'(pkts_dropped), 577'(exp_d));

      // Reset while beat 2 of a 5-beat valid frame is presented
      send_beat(mk_hdr(MAC_LOCAL, 16'd32002, 16'h0122, 16'd300), '1, 1'b0, s);
      in_tdata  = {64{8'hE2}};
      in_tkeep  = '1;
      in_tlast  = 1'b0;
      in_tvalid = 1'b1;
      resetn    = 1'b0;
      idle(2);
      resetn    = 1'b1;
      in_tvalid = 1'b0;
      @(negedge clk);
      chk("mid_rst_tvalid", 577'(out_tvalid), 577'd0);
      chk("mid_rst_tready", 577'(in_tready), 577'd1);
      chk("mid_rst_passed", 577'(pkts_passed), 577'd0);
      @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      send_beat({64{8'hE3}}, '1, 1'b0, s);
      send_beat({64{8'hE4}}, '1, 1'b0, s);
      send_beat({64{8'hE5}}, 64'h0000_0000_0000_FFFF, 1'b1, s);
      idle(10);
      check_out("rst");
      chk("rst_end_passed", 577'(pkts_passed), 577'd0);
      chk("rst_end_dropped", 577'(pkts_dropped), 577'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
